// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for data-memory port clients: master ids, burst counter
// width and the byte-address legality check.
package dmem_port_arbiter_pkg;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

    // Wide enough for MAX_BURST up to 15.
    localparam int unsigned BURST_W = 4;

    // 33-bit window compare so a window ending at 2^32 does not wrap.
    function automatic logic addr_bad(input logic [31:0] addr,
                                      input logic [32:0] lo,
                                      input logic [32:0] hi);
        return (addr[1:0] != 2'b00) || ({1'b0, addr} < lo) || ({1'b0, addr} >= hi);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_pick.sv
// Two-way round-robin picker: a lone requester always wins; on a tie the
// owner keeps the port until its burst is full, then the turn passes.
module dmem_rr_pick
    import dmem_port_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    input  logic       burst_full_i,
    output logic [1:0] gnt_o
);

    logic winner;

    always_comb begin
        gnt_o  = '0;
        winner = burst_full_i ? ~last_owner_i : last_owner_i;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (winner == ARB_M1) ? 2'b10 : 2'b01;
            default: gnt_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory read/write port between the load/store unit (M0)
// and the loader/debug DMA (M1), with range checking and registered returns.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] OFFSET    = '0,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_dataIn,
    output logic        mem_writeEnable,
    input  logic [31:0] mem_dataOut
);

    localparam logic [32:0]        ADDR_LO = {1'b0, OFFSET};
    localparam logic [32:0]        ADDR_HI = ADDR_LO + (33'(DEPTH) << 2);
    localparam logic [BURST_W-1:0] MAX_B   = BURST_W'(MAX_BURST);

    logic               last_owner_q, last_owner_d;
    logic               owner_vld_q, owner_vld_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [1:0]         rvalid_q, rvalid_d;
    logic [1:0]         err_q, err_d;
    logic [31:0]        rdata0_q, rdata0_d;
    logic [31:0]        rdata1_q, rdata1_d;

    logic [1:0]  pick_gnt, gnt;
    logic        owner_eff, accept, sel, sel_we, bad;
    logic [31:0] sel_addr, sel_wdata;

    // Until the first accept after reset nobody owns the port, so a tie goes
    // to the master opposite last_owner (M0), not to last_owner itself.
    assign owner_eff = owner_vld_q ? last_owner_q : ~last_owner_q;

    dmem_rr_pick u_pick (
        .req_i        ({m1_req, m0_req}),
        .last_owner_i (owner_eff),
        .burst_full_i (burst_cnt_q >= MAX_B),
        .gnt_o        (pick_gnt)
    );

    // No grant while reset is held, so nothing reaches the memory.
    assign gnt    = pick_gnt & {2{reset_n}};
    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];
    assign accept = |gnt;
    assign sel    = gnt[1] ? ARB_M1 : ARB_M0;

    assign sel_addr  = gnt[1] ? m1_addr  : m0_addr;
    assign sel_wdata = gnt[1] ? m1_wdata : m0_wdata;
    assign sel_we    = gnt[1] ? m1_we    : m0_we;
    assign bad       = addr_bad(sel_addr, ADDR_LO, ADDR_HI);

    assign mem_address     = sel_addr;
    assign mem_dataIn      = sel_wdata;
    assign mem_writeEnable = accept && sel_we && !bad;

    always_comb begin
        last_owner_d = last_owner_q;
        owner_vld_d  = owner_vld_q;
        burst_cnt_d  = '0;
        rvalid_d     = '0;
        err_d        = '0;
        rdata0_d     = '0;
        rdata1_d     = '0;
        if (accept) begin
            owner_vld_d  = 1'b1;
            last_owner_d = sel;
            if (sel == last_owner_q) begin
                burst_cnt_d = (burst_cnt_q >= MAX_B) ? MAX_B : burst_cnt_q + 1'b1;
            end else begin
                burst_cnt_d = BURST_W'(1);
            end
            rvalid_d[sel] = 1'b1;
            err_d[sel]    = bad;
            if (!sel_we && !bad) begin
                if (sel == ARB_M1) rdata1_d = mem_dataOut;
                else               rdata0_d = mem_dataOut;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner_q <= ARB_M1;
            owner_vld_q  <= 1'b0;
            burst_cnt_q  <= '0;
            rvalid_q     <= '0;
            err_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            owner_vld_q  <= owner_vld_d;
            burst_cnt_q  <= burst_cnt_d;
            rvalid_q     <= rvalid_d;
            err_q        <= err_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule
